// File: rtl/rom_burst_arbiter.sv
// Two-client round-robin burst reader for the 64x16 code ROM, one word per cycle with address wrap.
// Optional response backpressure (rsp_ready port) is enabled by defining ROM_ARB_BACKPRESSURE_EN.
module rom_burst_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid0,
  input  logic          req_valid1,
  output logic          req_ready0,
  output logic          req_ready1,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [AW-1:0] req_len0,
  input  logic [AW-1:0] req_len1,
  output logic          rom_cen,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q,
  output logic          rsp_valid,
`ifdef ROM_ARB_BACKPRESSURE_EN
  input  logic          rsp_ready,
`endif
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          rsp_last
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          prio_q, prio_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;

  logic          rsp_ready_int;
  logic          grant0, grant1;
  logic          accept, winner, issue, rsp_take;
  logic [AW-1:0] win_addr, win_len;

`ifdef ROM_ARB_BACKPRESSURE_EN
  assign rsp_ready_int = rsp_ready;
`else
  assign rsp_ready_int = 1'b1;
`endif

  // Arbitration and ROM strobe; issue is gated by RST so a reset drops the ROM enable at once.
  always_comb begin
    grant0     = req_valid0 & (~req_valid1 | ~prio_q);
    grant1     = req_valid1 & (~req_valid0 | prio_q);
    req_ready0 = (state_q == StIdle) & ~RST & grant0;
    req_ready1 = (state_q == StIdle) & ~RST & grant1;
    accept     = req_ready0 | req_ready1;
    winner     = req_ready1;
    win_addr   = winner ? req_addr1 : req_addr0;
    win_len    = winner ? req_len1 : req_len0;
    rsp_take   = rsp_valid_q & rsp_ready_int;
    issue      = (state_q == StBusy) & ~RST & (remain_q != '0) & (~rsp_valid_q | rsp_ready_int);
    rom_cen    = ~issue;
    rom_a      = cur_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d    = winner;
          cur_addr_d = win_addr;
          remain_d   = (AW+1)'(win_len) + (AW+1)'(1);
          prio_d     = ~winner;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + AW'(1);
          remain_d    = remain_q - (AW+1)'(1);
          rsp_valid_d = 1'b1;
          rsp_last_d  = (remain_q == (AW+1)'(1));
        end else if (rsp_take) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
        end
        // The last word can never coincide with an issue since remain is already zero.
        if (rsp_take & rsp_last_q) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_id    = owner_q;
  assign rsp_data  = rom_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter with a behavioural registered ROM model.
module tb_rom_burst_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [5:0]  req_addr0, req_addr1, req_len0, req_len1;
  logic        rom_cen;
  logic [5:0]  rom_a;
  logic [15:0] rom_q;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_last;
  logic [15:0] rsp_data;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rom_burst_arbiter #(.AW(6), .DW(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid0(req_valid0),
    .req_valid1(req_valid1),
    .req_ready0(req_ready0),
    .req_ready1(req_ready1),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_len0  (req_len0),
    .req_len1  (req_len1),
    .rom_cen   (rom_cen),
    .rom_a     (rom_a),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
`ifdef ROM_ARB_BACKPRESSURE_EN
    .rsp_ready (rsp_ready),
`endif
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last)
  );

  function automatic logic [15:0] memval(input int i);
    return 16'((i * 1103) ^ 23100);
  endfunction

  // ROM: output registered on an enabled edge, held otherwise.
  always @(posedge CLK) if (!rom_cen) rom_q <= memval(int'(rom_a));

  task automatic test_reset();
    RST = 1'b1; req_valid0 = 1'b1; req_valid1 = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    checks++;
    if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", req_ready1, req_ready0);
    end
    checks++;
    if (rom_cen !== 1'b1 || rom_a !== 6'd0) begin
      errors++; $display("FAIL reset_rom: got cen=%b a=%0d want cen=1 a=0", rom_cen, rom_a);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b l=%b id=%b want 0 0 0", rsp_valid, rsp_last, rsp_id);
    end
    RST = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
  endtask

  // Issue one burst from a single client and check every ROM address and response word.
  task automatic run_burst(input int client, input int addr, input int len, input int stall_at,
                           input int stall_len, input string name);
    int k, issued, cyc, first_cyc, stall_left;
    bit stalling;
    logic [5:0] ea;
    k = 0; issued = 0; cyc = 0; first_cyc = -1; stall_left = stall_len;
    @(negedge CLK);
    if (client == 0) begin
      req_valid0 = 1'b1; req_addr0 = addr[5:0]; req_len0 = len[5:0];
    end else begin
      req_valid1 = 1'b1; req_addr1 = addr[5:0]; req_len1 = len[5:0];
    end
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rom_cen !== 1'b1) begin
      errors++; $display("FAIL %s_idle: got v=%b cen=%b want 0 1", name, rsp_valid, rom_cen);
    end
    checks++;
    if ({req_ready1, req_ready0} !== ((client == 1) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL %s_grant: got ready1/0=%b%b want client %0d", name, req_ready1, req_ready0,
               client);
    end
    @(posedge CLK);
    while (k <= len && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      stalling = rsp_valid && (k == stall_at) && (stall_left > 0);
      if (stalling) stall_left--;
      rsp_ready = !stalling;
      #1;
      if (!rom_cen) begin
        ea = 6'((addr + issued) % 64);
        checks++;
        if (rom_a !== ea) begin
          errors++; $display("FAIL %s_addr: issue %0d got %0d want %0d", name, issued, rom_a, ea);
        end
        issued++;
      end
      if (stalling) begin
        checks++;
        if (rom_cen !== 1'b1) begin
          errors++; $display("FAIL %s_stall_cen: got %b want 1", name, rom_cen);
        end
      end
      if (rsp_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          checks++;
          if (cyc != 2) begin
            errors++; $display("FAIL %s_latency: got %0d cycles want 2", name, cyc);
          end
        end
        checks++;
        if (rsp_data !== memval((addr + k) % 64) || rsp_id !== client[0] ||
            rsp_last !== (k == len)) begin
          errors++;
          $display("FAIL %s_word%0d: got d=%h id=%b last=%b want d=%h id=%0d last=%0d", name, k,
                   rsp_data, rsp_id, rsp_last, memval((addr + k) % 64), client, k == len);
        end
        if (rsp_ready) k++;
      end
    end
    rsp_ready = 1'b1;
    checks++;
    if (k != len + 1 || issued != len + 1) begin
      errors++;
      $display("FAIL %s_count: got words=%0d issues=%0d want %0d", name, k, issued, len + 1);
    end
  endtask

  task automatic test_single();
    run_burst(0, 5, 3, -1, 0, "single");
  endtask

  task automatic test_wrap();
    run_burst(1, 62, 3, -1, 0, "wrap");
  endtask

  task automatic test_max_burst();
    run_burst(0, 0, 63, -1, 0, "max");
  endtask

  // Both clients held valid; expect grants alternating from client 0.
  task automatic test_back_to_back();
    int exp_order[4];
    int grants, cnt0, cnt1, wk, base;
    logic w, owner;
    exp_order = '{0, 1, 0, 1};
    grants = 0; cnt0 = 0; cnt1 = 0; wk = 0; base = 0; owner = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    req_valid0 = 1'b1; req_addr0 = 6'd40; req_len0 = 6'd1;
    req_valid1 = 1'b1; req_addr1 = 6'd50; req_len1 = 6'd1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge CLK);
      if (cnt0 == 2) req_valid0 = 1'b0;
      if (cnt1 == 2) req_valid1 = 1'b0;
      #1;
      if (req_ready0 && req_ready1) begin
        checks++; errors++; $display("FAIL arb_both_ready: got 11 want at most one");
      end else if (req_ready0 || req_ready1) begin
        w = req_ready1;
        checks++;
        if (grants < 4 && int'(w) != exp_order[grants]) begin
          errors++; $display("FAIL arb_order%0d: got %0d want %0d", grants, w, exp_order[grants]);
        end
        owner = w; base = w ? 50 : 40; wk = 0;
        grants++;
        if (w) cnt1++; else cnt0++;
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== owner || rsp_data !== memval(base + wk)) begin
          errors++;
          $display("FAIL arb_word: got id=%b d=%h want id=%b d=%h", rsp_id, rsp_data, owner,
                   memval(base + wk));
        end
        wk++;
      end
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    checks++;
    if (grants != 4 || cnt0 != 2 || cnt1 != 2) begin
      errors++; $display("FAIL arb_counts: got g=%0d c0=%0d c1=%0d want 4 2 2", grants, cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    run_burst(1, 12, 3, 1, 3, "stall");
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    req_valid0 = 1'b1; req_addr0 = 6'd10; req_len0 = 6'd3;
    @(posedge CLK);
    @(negedge CLK); req_valid0 = 1'b0;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== memval(11)) begin
      errors++; $display("FAIL rstmid_word2: got v=%b d=%h want 1 %h", rsp_valid, rsp_data, memval(11));
    end
    RST = 1'b1; #1;
    checks++;
    if (rom_cen !== 1'b1) begin
      errors++; $display("FAIL rstmid_cen_now: got %b want 1", rom_cen);
    end
    @(negedge CLK); RST = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rom_cen !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after: got v=%b l=%b cen=%b want 0 0 1", rsp_valid, rsp_last, rom_cen);
    end
    req_valid0 = 1'b1; req_valid1 = 1'b1; #1;
    checks++;
    if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_prio: got ready1/0=%b%b want 01", req_ready1, req_ready0);
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    run_burst(1, 30, 3, -1, 0, "post_rst");
  endtask

  initial begin
    RST = 1'b1; rsp_ready = 1'b1; rom_q = 16'h0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_max_burst();
`ifdef ROM_ARB_BACKPRESSURE_EN
    test_backpressure();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
